// File: rtl/adc_sar_sequencer.sv
// adc_sar_sequencer: successive-approximation control sequencer.
// Runs sample -> 12 trial/wait bit decisions -> done for each accepted start,
// driving the capacitor DAC trial code and the comparator strobe.
// Optional build macro ADC_OVERSAMPLE_EN: one start runs 2^AVG_LOG2
// conversions and reports their truncated average.
`timescale 1ns/1ps
module adc_sar_sequencer #(
  parameter int SAMPLE_CYCLES = 4,
  parameter int AVG_LOG2      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        comp_out,
  input  logic        comp_valid,
  output logic [11:0] dac_code,
  output logic        sample_out,
  output logic        comp_trig,
  output logic        busy,
  output logic [11:0] result,
  output logic        result_valid
);

  typedef enum logic [2:0] {IDLE, SAMPLE, TRIAL, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  k, k_nxt;
  logic [11:0] work, work_nxt, work_upd;
  logic [7:0]  cnt, cnt_nxt;
  logic [11:0] dac_nxt, result_nxt;
  logic        sample_nxt, trig_nxt, rv_nxt;

`ifdef ADC_OVERSAMPLE_EN
  localparam int ACC_W = 12 + AVG_LOG2;
  logic [ACC_W-1:0]    acc, acc_nxt, acc_sum;
  logic [AVG_LOG2-1:0] conv, conv_nxt;
`endif

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    state_nxt  = state;
    k_nxt      = k;
    work_nxt   = work;
    cnt_nxt    = cnt;
    dac_nxt    = dac_code;
    sample_nxt = 1'b0;
    trig_nxt   = 1'b0;
    result_nxt = result;
    rv_nxt     = 1'b0;
    work_upd    = work;
    work_upd[k] = comp_out;
`ifdef ADC_OVERSAMPLE_EN
    acc_nxt  = acc;
    conv_nxt = conv;
    acc_sum  = acc + {{AVG_LOG2{1'b0}}, work};
`endif
    case (state)
      IDLE: begin
        // A start coinciding with the result pulse is dropped on purpose.
        if (start && !result_valid) begin
          state_nxt  = SAMPLE;
          cnt_nxt    = 8'd0;
          sample_nxt = 1'b1;
          dac_nxt    = 12'd0;
`ifdef ADC_OVERSAMPLE_EN
          acc_nxt  = '0;
          conv_nxt = '0;
`endif
        end
      end
      SAMPLE: begin
        if (cnt == 8'(SAMPLE_CYCLES - 1)) begin
          state_nxt = TRIAL;
          k_nxt     = 4'd11;
          work_nxt  = 12'd0;
          dac_nxt   = 12'h800;
          trig_nxt  = 1'b1;
        end else begin
          cnt_nxt    = cnt + 8'd1;
          sample_nxt = 1'b1;
        end
      end
      TRIAL: state_nxt = WAIT;
      WAIT: begin
        if (comp_valid) begin
          work_nxt = work_upd;
          if (k == 4'd0) begin
            state_nxt = DONE;
            dac_nxt   = 12'd0;
          end else begin
            // Next trial: decided bits kept, next bit set, lower bits still zero.
            k_nxt     = k - 4'd1;
            state_nxt = TRIAL;
            dac_nxt   = work_upd | (12'd1 << (k - 4'd1));
            trig_nxt  = 1'b1;
          end
        end
      end
      DONE: begin
        k_nxt = 4'd11;
`ifdef ADC_OVERSAMPLE_EN
        if (&conv) begin
          result_nxt = 12'(acc_sum >> AVG_LOG2);
          rv_nxt     = 1'b1;
          state_nxt  = IDLE;
          acc_nxt    = '0;
        end else begin
          acc_nxt    = acc_sum;
          conv_nxt   = conv + 1'b1;
          state_nxt  = SAMPLE;
          cnt_nxt    = 8'd0;
          sample_nxt = 1'b1;
        end
`else
        result_nxt = work;
        rv_nxt     = 1'b1;
        state_nxt  = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      k            <= 4'd11;
      work         <= 12'd0;
      cnt          <= 8'd0;
      dac_code     <= 12'd0;
      sample_out   <= 1'b0;
      comp_trig    <= 1'b0;
      busy         <= 1'b0;
      result       <= 12'd0;
      result_valid <= 1'b0;
`ifdef ADC_OVERSAMPLE_EN
      acc  <= '0;
      conv <= '0;
`endif
    end else begin
      state        <= state_nxt;
      k            <= k_nxt;
      work         <= work_nxt;
      cnt          <= cnt_nxt;
      dac_code     <= dac_nxt;
      sample_out   <= sample_nxt;
      comp_trig    <= trig_nxt;
      busy         <= (state_nxt != IDLE);
      result       <= result_nxt;
      result_valid <= rv_nxt;
`ifdef ADC_OVERSAMPLE_EN
      acc  <= acc_nxt;
      conv <= conv_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Testbench for adc_sar_sequencer: behavioural comparator with configurable
// response delay, randomized input codes, latency/result/trial checks.
`timescale 1ns/1ps
module tb_adc_sar_sequencer;

  localparam int S = 4;
`ifdef ADC_OVERSAMPLE_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        comp_out = 1'b0;
  logic        comp_valid = 1'b0;
  logic [11:0] dac_code;
  logic        sample_out, comp_trig, busy, result_valid;
  logic [11:0] result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // comparator model state
  logic [11:0] codes [4];
  int          cmp_delay = 0;
  int          cd = 0;
  int          idx = 0;
  logic [11:0] lat_code = 12'd0;
  int          trig_cnt = 0, hold_err = 0, rv_cnt = 0;
  logic [11:0] trials [$];

  adc_sar_sequencer #(.SAMPLE_CYCLES(S), .AVG_LOG2(2)) dut (
    .clk(clk), .rst(rst), .start(start), .comp_out(comp_out),
    .comp_valid(comp_valid), .dac_code(dac_code), .sample_out(sample_out),
    .comp_trig(comp_trig), .busy(busy), .result(result),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Comparator: answers each strobe after 1+cmp_delay cycles, checks dac hold.
  always @(posedge clk) begin
    #1;
    comp_valid = 1'b0;
    if (rst) begin
      cd = 0;
      idx = 0;
    end else begin
      if (!busy) idx = 0;
      if (cd > 0) begin
        if (dac_code !== lat_code) hold_err++;
        cd--;
        if (cd == 0) begin
          comp_valid = 1'b1;
          comp_out = (codes[idx] >= lat_code);
          if (lat_code[0]) idx = (idx + 1) % 4;
        end
      end
      if (comp_trig) begin
        trig_cnt++;
        lat_code = dac_code;
        trials.push_back(dac_code);
        cd = 1 + cmp_delay;
      end
      if (result_valid) rv_cnt++;
    end
  end

  // Binary-search reference: i-th trial level for an input code.
  function automatic logic [11:0] model_trial(input logic [11:0] code, input int i);
    int lo = 0;
    int step = 2048;
    for (int n = 0; n < i; n++) begin
      if (int'(code) >= lo + step) lo = lo + step;
      step = step / 2;
    end
    return 12'(lo + step);
  endfunction

  task automatic run_conv(input logic [11:0] code, input int dly, output int lat,
                          output logic [11:0] res, output int ntrig, output int nhold,
                          output int nrv, output int tbase);
    int t0, h0, r0, c0;
    bit seen;
    for (int i = 0; i < 4; i++) codes[i] = code;
    cmp_delay = dly;
    t0 = trig_cnt; h0 = hold_err; r0 = rv_cnt; tbase = trials.size();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c0 = cyc;
    seen = 1'b0; lat = -1; res = 'x;
    for (int i = 0; i < 4000 && !seen; i++) begin
      if (result_valid) begin
        seen = 1'b1; lat = cyc - c0; res = result;
      end else @(negedge clk);
    end
    @(negedge clk);
    ntrig = trig_cnt - t0; nhold = hold_err - h0; nrv = rv_cnt - r0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (dac_code !== 12'd0) begin errors++; $display("FAIL rst_dac got=%0d want=0", dac_code); end
    checks++; if (sample_out !== 1'b0) begin errors++; $display("FAIL rst_sample got=%b want=0", sample_out); end
    checks++; if (comp_trig !== 1'b0) begin errors++; $display("FAIL rst_trig got=%b want=0", comp_trig); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (result !== 12'd0) begin errors++; $display("FAIL rst_result got=%0d want=0", result); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_rv got=%b want=0", result_valid); end
    // first start on the first edge after release
    for (int i = 0; i < 4; i++) codes[i] = 12'd1000;
    cmp_delay = 0;
    rst = 1'b0; start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_start_busy got=%b want=1", busy); end
    checks++; if (sample_out !== 1'b1) begin errors++; $display("FAIL first_start_sample got=%b want=1", sample_out); end
    for (int i = 0; i < 4000 && !result_valid; i++) @(negedge clk);
    checks++; if (result !== 12'd1000) begin errors++; $display("FAIL first_start_result got=%0d want=1000", result); end
    @(negedge clk);
  endtask

  task automatic test_known_code;
    logic [11:0] exp_tr [12] = '{12'd2048, 12'd3072, 12'd2560, 12'd2816, 12'd2688, 12'd2752,
                                 12'd2720, 12'd2736, 12'd2728, 12'd2732, 12'd2730, 12'd2731};
    int lat, ntrig, nhold, nrv, tb; logic [11:0] res;
    run_conv(12'd2730, 0, lat, res, ntrig, nhold, nrv, tb);
    checks++; if (res !== 12'd2730) begin errors++; $display("FAIL known_result got=%0d want=2730", res); end
    checks++; if (lat !== NCONV * (S + 25)) begin errors++; $display("FAIL known_latency got=%0d want=%0d", lat, NCONV * (S + 25)); end
    checks++; if (ntrig !== 12 * NCONV) begin errors++; $display("FAIL known_trigs got=%0d want=%0d", ntrig, 12 * NCONV); end
    checks++; if (nrv !== 1) begin errors++; $display("FAIL known_rv_count got=%0d want=1", nrv); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (trials[tb + i] !== exp_tr[i]) begin
        errors++; $display("FAIL known_trial%0d got=%0d want=%0d", i, trials[tb + i], exp_tr[i]);
      end
    end
  endtask

  task automatic test_extremes;
    int lat, ntrig, nhold, nrv, tb; logic [11:0] res;
    run_conv(12'd4095, 0, lat, res, ntrig, nhold, nrv, tb);
    checks++; if (res !== 12'd4095) begin errors++; $display("FAIL all_ones_result got=%0d want=4095", res); end
    checks++; if (dac_code !== 12'd0) begin errors++; $display("FAIL idle_dac got=%0d want=0", dac_code); end
    run_conv(12'd0, 0, lat, res, ntrig, nhold, nrv, tb);
    checks++; if (res !== 12'd0) begin errors++; $display("FAIL all_zeros_result got=%0d want=0", res); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_random;
    int lat, ntrig, nhold, nrv, tb, dly, bad; logic [11:0] res, code;
    for (int n = 0; n < 6; n++) begin
      code = 12'($urandom_range(0, 4095));
      dly = $urandom_range(0, 3);
      run_conv(code, dly, lat, res, ntrig, nhold, nrv, tb);
      checks++; if (res !== code) begin errors++; $display("FAIL rand_result got=%0d want=%0d", res, code); end
      checks++; if (lat !== NCONV * (S + 25 + 12 * dly)) begin errors++; $display("FAIL rand_latency got=%0d want=%0d", lat, NCONV * (S + 25 + 12 * dly)); end
      checks++; if (nhold !== 0) begin errors++; $display("FAIL rand_dac_hold got=%0d want=0", nhold); end
      bad = 0;
      for (int i = 0; i < 12; i++) if (trials[tb + i] !== model_trial(code, i)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL rand_trials code=%0d wrong=%0d want=0", code, bad); end
    end
  endtask

  task automatic test_slow_comparator;
    int lat, ntrig, nhold, nrv, tb; logic [11:0] res, code;
    code = 12'($urandom_range(0, 4095));
    run_conv(code, 5, lat, res, ntrig, nhold, nrv, tb);
    checks++; if (res !== code) begin errors++; $display("FAIL slow_result got=%0d want=%0d", res, code); end
    checks++; if (lat !== NCONV * (S + 25 + 60)) begin errors++; $display("FAIL slow_latency got=%0d want=%0d", lat, NCONV * (S + 85)); end
    checks++; if (nhold !== 0) begin errors++; $display("FAIL slow_dac_hold got=%0d want=0", nhold); end
    checks++; if (ntrig !== 12 * NCONV) begin errors++; $display("FAIL slow_trigs got=%0d want=%0d", ntrig, 12 * NCONV); end
  endtask

  task automatic test_back_to_back;
    int r0, k; logic [11:0] code;
    code = 12'($urandom_range(0, 4095));
    for (int i = 0; i < 4; i++) codes[i] = code;
    cmp_delay = 0;
    r0 = rv_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;            // during SAMPLE
    @(negedge clk) start = 1'b0;
    for (k = 0; k < 200 && !comp_trig; k++) @(negedge clk);
    start = 1'b1;                           // during TRIAL
    @(negedge clk) start = 1'b0;
    for (k = 0; k < 4000 && !result_valid; k++) @(negedge clk);
    checks++; if (result !== code) begin errors++; $display("FAIL b2b_result got=%0d want=%0d", result, code); end
    start = 1'b1;                           // during result_valid
    @(negedge clk) start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_rv_start_ignored busy=%b want=0", busy); end
    start = 1'b1;                           // following idle cycle
    @(negedge clk) start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_next_start busy=%b want=1", busy); end
    for (k = 0; k < 4000 && !result_valid; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++; if (rv_cnt - r0 !== 2) begin errors++; $display("FAIL b2b_rv_count got=%0d want=2", rv_cnt - r0); end
  endtask

  task automatic test_reset_mid;
    int t0, r0, k, lat, ntrig, nhold, nrv, tb; logic [11:0] res, code;
    code = 12'($urandom_range(0, 4095));
    for (int i = 0; i < 4; i++) codes[i] = code;
    cmp_delay = 3;
    t0 = trig_cnt; r0 = rv_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (k = 0; k < 500 && (trig_cnt - t0) < 6; k++) @(negedge clk);
    @(negedge clk);                         // bit 6 WAIT
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dac_code, sample_out, comp_trig, busy, result, result_valid} !== 28'd0) begin
      errors++; $display("FAIL midrst_outputs dac=%0d smp=%b trg=%b busy=%b res=%0d rv=%b want all 0",
                         dac_code, sample_out, comp_trig, busy, result, result_valid);
    end
    @(negedge clk) rst = 1'b0;
    repeat (60) @(negedge clk);
    checks++; if (rv_cnt - r0 !== 0) begin errors++; $display("FAIL midrst_no_rv got=%0d want=0", rv_cnt - r0); end
    checks++; if (result !== 12'd0) begin errors++; $display("FAIL midrst_result got=%0d want=0", result); end
    run_conv(code, 0, lat, res, ntrig, nhold, nrv, tb);
    checks++; if (res !== code) begin errors++; $display("FAIL midrst_reconvert got=%0d want=%0d", res, code); end
  endtask

`ifdef ADC_OVERSAMPLE_EN
  task automatic test_oversample;
    int r0, c0, lat, drop; bit seen;
    codes[0] = 12'd100; codes[1] = 12'd101; codes[2] = 12'd102; codes[3] = 12'd104;
    cmp_delay = 0; r0 = rv_cnt; drop = 0; seen = 1'b0; lat = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 4000 && !seen; i++) begin
      if (result_valid) begin seen = 1'b1; lat = cyc - c0; end
      else begin if (!busy) drop++; @(negedge clk); end
    end
    checks++; if (result !== 12'd101) begin errors++; $display("FAIL os_result got=%0d want=101", result); end
    checks++; if (lat !== 4 * (S + 25)) begin errors++; $display("FAIL os_latency got=%0d want=%0d", lat, 4 * (S + 25)); end
    checks++; if (drop !== 0) begin errors++; $display("FAIL os_busy_drops got=%0d want=0", drop); end
    repeat (5) @(negedge clk);
    checks++; if (rv_cnt - r0 !== 1) begin errors++; $display("FAIL os_rv_count got=%0d want=1", rv_cnt - r0); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) codes[i] = 12'd0;
    test_reset;
    test_known_code;
    test_extremes;
    test_random;
    test_slow_comparator;
    test_back_to_back;
    test_reset_mid;
`ifdef ADC_OVERSAMPLE_EN
    test_oversample;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_sar_sequencer.md
ADC_SAR_SEQUENCER -- requirements
Module: adc_sar_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_CYCLES, default 4, number of clock cycles the sample switch is closed (range 1..255).
REQ-002 SHALL have parameter AVG_LOG2, default 2, log2 of conversions averaged when ADC_OVERSAMPLE_EN is defined (range 1..3).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, conversion request, sampled each cycle.
REQ-006 SHALL have port comp_out, input, 1, comparator decision: 1 = input above DAC trial level.
REQ-007 SHALL have port comp_valid, input, 1, comp_out qualifier, one-cycle pulse.
REQ-008 SHALL have port dac_code, output, 12, trial code driving the row/column capacitor decoder data input.
REQ-009 SHALL have port sample_out, output, 1, sample switch enable.
REQ-010 SHALL have port comp_trig, output, 1, one-cycle comparator strobe.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 SHALL have port result, output, 12, last completed conversion, held until next completion.
REQ-013 SHALL have port result_valid, output, 1, one-cycle pulse when result updates.

Function
REQ-014 SHALL implement states IDLE, SAMPLE, TRIAL, WAIT, DONE.
REQ-015 IDLE: start=1 SHALL move to SAMPLE next cycle; start during any other state SHALL be ignored (not queued).
REQ-016 SAMPLE: sample_out=1 for exactly SAMPLE_CYCLES cycles, dac_code=12'd0, then TRIAL with bit index k=11 and working register cleared.
REQ-017 TRIAL: dac_code = working bits above k, bit k=1, bits below k=0; comp_trig=1 for this one cycle; next state WAIT.
REQ-018 WAIT: hold dac_code; on comp_valid=1 set working bit k = comp_out; if k=0 go DONE, else k=k-1 and go TRIAL; without comp_valid remain in WAIT indefinitely.
REQ-019 comp_valid in any state other than WAIT SHALL be ignored.
REQ-020 DONE: result <= working register, result_valid=1 for one cycle, next state IDLE; dac_code returns to 12'd0.
REQ-021 With comp_valid arriving the cycle after comp_trig, latency from start-accept edge to result_valid SHALL be SAMPLE_CYCLES + 24 + 1 cycles.
REQ-022 A start asserted in the same cycle as result_valid SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-023 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, dac_code=0, sample_out=0, comp_trig=0, busy=0, result=0, result_valid=0, k=11, accumulator=0.
REQ-025 rst asserted mid-conversion SHALL abort it with no result_valid; result keeps reset value 0.
REQ-026 First start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro ADC_OVERSAMPLE_EN SHALL select oversampling.
REQ-028 With ADC_OVERSAMPLE_EN defined: one start SHALL run 2^AVG_LOG2 back-to-back SAMPLE..DONE-internal conversions, accumulate in a (12+AVG_LOG2)-bit sum, and pulse result_valid once with result = sum >> AVG_LOG2 (truncated); busy stays high throughout; intermediate conversions SHALL NOT pulse result_valid.
REQ-029 Without ADC_OVERSAMPLE_EN: single conversion per start, no accumulator hardware.

Verification
REQ-030 Comparator model with input code 12'd2730: start pulse -> trial sequence 2048,3072,2560,2816,2688,2752,2720,2736,2728,2732,2730,2731, result=2730, result_valid after SAMPLE_CYCLES+25 cycles.
REQ-031 comp_out always 1 -> result=4095; comp_out always 0 -> result=0; dac_code 0 in IDLE.
REQ-032 comp_valid delayed 5 cycles per bit -> WAIT holds dac_code, comp_trig single pulse per bit, result still correct.
REQ-033 start re-pulsed during SAMPLE, TRIAL and the result_valid cycle -> ignored, exactly one result_valid per accepted start.
REQ-034 rst pulsed during bit 6 WAIT -> all outputs 0 within same cycle, no result_valid; next start converts correctly.
REQ-035 ADC_OVERSAMPLE_EN, AVG_LOG2=2, model codes 100,101,102,104 -> one result_valid, result=101.
